// File: rtl/inst_mem_if.sv
// Fetch-side bus for inst_mem_pipe: request/response handshake, flush and program-load port.
// The fetch stage or bench uses the master modport; the memory uses the slave modport.
interface inst_mem_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_pc;
   logic                  flush;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_inst;
   logic [31:0]           resp_pc;
   logic                  resp_fault;
   logic                  ld_en;
   logic [31:0]           ld_addr;
   logic [DATA_WIDTH-1:0] ld_data;

   modport master (
      output req_valid, req_pc, flush, resp_ready, ld_en, ld_addr, ld_data,
      input  req_ready, resp_valid, resp_inst, resp_pc, resp_fault
   );

   modport slave (
      input  req_valid, req_pc, flush, resp_ready, ld_en, ld_addr, ld_data,
      output req_ready, resp_valid, resp_inst, resp_pc, resp_fault
   );
endinterface

// File: rtl/inst_mem_pipe.sv
// Pipelined synchronous-read instruction memory (1 or 2 cycle latency) with flush and load port.
// Optional fault reporting on misaligned/out-of-range pcs: define INSTMEM_FAULT_CHECK_EN.
module inst_mem_pipe #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          DEPTH_WORDS = 131072,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   inst_mem_if.slave    bus
);

   localparam int OFF_W = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [DATA_WIDTH-1:0] NOP_EXT = DATA_WIDTH'(NOP_WORD);
   localparam logic [31:0] LO_MASK = (32'd1 << OFF_W) - 32'd1;
   localparam logic [31:0] HI_MASK = ~((32'd1 << (OFF_W + IDX_W)) - 32'd1);
`ifdef INSTMEM_FAULT_CHECK_EN
   localparam logic FAULT_EN = 1'b1;
`else
   localparam logic FAULT_EN = 1'b0;
`endif

   function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
      return IDX_W'(a >> OFF_W);
   endfunction

   // With checking disabled the whole pc still feeds this, so the mask folds to a constant 0.
   function automatic logic addr_fault(input logic [31:0] a);
      return FAULT_EN & ((|(a & LO_MASK)) | (|(a & HI_MASK)));
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

   logic                  s1_valid_r;
   logic [31:0]           s1_pc_r;
   logic [DATA_WIDTH-1:0] s1_inst_r;
   logic                  s1_fault_r;

   logic                  s1_adv_s;
   logic                  req_fault_s;
   logic                  req_ready_s;
   logic                  accept_s;

   // Request acceptance: blocked by flush/reset or a full first stage.
   always_comb begin
      req_fault_s = addr_fault(bus.req_pc);
      req_ready_s = !reset && !bus.flush && (!s1_valid_r || s1_adv_s);
      accept_s    = bus.req_valid && req_ready_s;
   end

   assign bus.req_ready = req_ready_s;

   // Program-load write port; faulting writes and writes during reset are dropped.
   always_ff @(posedge clk) begin
      if (!reset && bus.ld_en && !addr_fault(bus.ld_addr)) begin
         mem_r[word_index(bus.ld_addr)] <= bus.ld_data;
      end
   end

   // S1: array read stage; data falls back to NOP whenever the stage empties.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_pc_r    <= 32'd0;
         s1_inst_r  <= NOP_EXT;
         s1_fault_r <= 1'b0;
      end else if (bus.flush) begin
         s1_valid_r <= 1'b0;
         s1_inst_r  <= NOP_EXT;
         s1_fault_r <= 1'b0;
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_pc_r    <= bus.req_pc;
         s1_fault_r <= req_fault_s;
         s1_inst_r  <= req_fault_s ? NOP_EXT : mem_r[word_index(bus.req_pc)];
      end else if (s1_adv_s) begin
         s1_valid_r <= 1'b0;
         s1_inst_r  <= NOP_EXT;
         s1_fault_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         logic                  s2_valid_r;
         logic [31:0]           s2_pc_r;
         logic [DATA_WIDTH-1:0] s2_inst_r;
         logic                  s2_fault_r;
         logic                  s2_adv_s;

         assign s2_adv_s = s2_valid_r && bus.resp_ready;
         assign s1_adv_s = s1_valid_r && (!s2_valid_r || s2_adv_s);

         // S2: output register, holds steady while the consumer stalls.
         always_ff @(posedge clk) begin
            if (reset) begin
               s2_valid_r <= 1'b0;
               s2_pc_r    <= 32'd0;
               s2_inst_r  <= NOP_EXT;
               s2_fault_r <= 1'b0;
            end else if (bus.flush) begin
               s2_valid_r <= 1'b0;
               s2_inst_r  <= NOP_EXT;
               s2_fault_r <= 1'b0;
            end else if (s1_adv_s) begin
               s2_valid_r <= 1'b1;
               s2_pc_r    <= s1_pc_r;
               s2_inst_r  <= s1_inst_r;
               s2_fault_r <= s1_fault_r;
            end else if (s2_adv_s) begin
               s2_valid_r <= 1'b0;
               s2_inst_r  <= NOP_EXT;
               s2_fault_r <= 1'b0;
            end else begin
               s2_valid_r <= s2_valid_r;
            end
         end

         assign bus.resp_valid = s2_valid_r;
         assign bus.resp_pc    = s2_pc_r;
         assign bus.resp_inst  = s2_inst_r;
         assign bus.resp_fault = s2_fault_r;
      end else begin : g_lat1
         assign s1_adv_s       = s1_valid_r && bus.resp_ready;
         assign bus.resp_valid = s1_valid_r;
         assign bus.resp_pc    = s1_pc_r;
         assign bus.resp_inst  = s1_inst_r;
         assign bus.resp_fault = s1_fault_r;
      end
   endgenerate

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Scoreboard bench for inst_mem_pipe (LATENCY=2): the driver queues expected responses on
// acceptance, a negedge monitor pops and compares every consumed response.
module tb_inst_mem_pipe;
   localparam int          DW  = 32;
   localparam int          LAT = 2;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_mem_if #(.DATA_WIDTH(DW)) bus();

   inst_mem_pipe #(
      .DATA_WIDTH(DW), .DEPTH_WORDS(131072), .LATENCY(LAT), .NOP_WORD(NOP)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_pass  = 0;
   int          n_total = 0;
   int          cyc     = 0;
   bit          lat_chk = 1'b0;
   logic [31:0] nx_inst;
   logic        nx_fault;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: one pop per consumed response.
   always @(negedge clk) begin
      if (!reset && bus.resp_valid && bus.resp_ready) begin
         if (sb_q.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("resp_inst", bus.resp_inst, mon_e.inst);
            check("resp_pc", bus.resp_pc, mon_e.pc);
            check("resp_fault", bus.resp_fault, mon_e.fault);
            if (mon_e.cyc >= 0) check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic step(output bit acc);
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      if (acc) sb_q.push_back('{pc: bus.req_pc, inst: nx_inst, fault: nx_fault,
                                cyc: (lat_chk ? cyc + LAT : -1)});
      @(posedge clk);
      #1;
      if (reset || bus.flush) sb_q.delete();
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
      bit acc = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_pc    = pc;
      nx_inst       = inst;
      nx_fault      = fault;
      for (int i = 0; i < 20 && !acc; i++) step(acc);
      if (!acc) check("fetch_accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      bit acc;
      bus.ld_en   = 1'b1;
      bus.ld_addr = addr;
      bus.ld_data = data;
      step(acc);
      bus.ld_en   = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(acc);
      check("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_pc     = 32'd0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b1;
      bus.ld_en      = 1'b0;
      bus.ld_addr    = 32'd0;
      bus.ld_data    = 32'd0;
      nx_inst        = 32'd0;
      nx_fault       = 1'b0;

      // Reset state
      @(posedge clk); #1;
      check("rst_resp_valid", bus.resp_valid, 64'd0);
      check("rst_resp_inst", bus.resp_inst, NOP);
      check("rst_resp_pc", bus.resp_pc, 64'd0);
      check("rst_resp_fault", bus.resp_fault, 64'd0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", bus.req_ready, 64'd1);

      // A load issued during reset must be ignored
      load(32'h0000_001C, 32'h1111_1111);
      reset       = 1'b1;
      bus.ld_en   = 1'b1;
      bus.ld_addr = 32'h0000_001C;
      bus.ld_data = 32'hDEAD_BEEF;
      step(acc);
      reset     = 1'b0;
      bus.ld_en = 1'b0;

      load(32'h0000_0000, 32'h2408_0001);
      load(32'h0000_0004, 32'h2409_0002);
      load(32'h0000_0008, 32'h0109_5020);
      load(32'h0000_000C, 32'h0800_0000);
      load(32'h0000_0014, 32'hAAAA_AAAA);
      load(32'h0000_0040, 32'h2010_0040);

      // Back-to-back fetch, exact latency and no bubbles
      lat_chk = 1'b1;
      fetch(32'h0000_0000, 32'h2408_0001, 1'b0);
      fetch(32'h0000_0004, 32'h2409_0002, 1'b0);
      fetch(32'h0000_0008, 32'h0109_5020, 1'b0);
      fetch(32'h0000_000C, 32'h0800_0000, 1'b0);
      fetch(32'h0000_001C, 32'h1111_1111, 1'b0);
      drain();
      lat_chk = 1'b0;

      // Backpressure
      bus.resp_ready = 1'b0;
      fetch(32'h0000_0000, 32'h2408_0001, 1'b0);
      fetch(32'h0000_0004, 32'h2409_0002, 1'b0);
      check("bp_req_ready", bus.req_ready, 64'd0);
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0000_0008;
      nx_inst       = 32'h0109_5020;
      nx_fault      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(acc);
         check("bp_no_accept", 64'(acc), 64'd0);
         check("bp_valid_hold", bus.resp_valid, 64'd1);
         check("bp_inst_hold", bus.resp_inst, 32'h2408_0001);
      end
      bus.resp_ready = 1'b1;
      fetch(32'h0000_0008, 32'h0109_5020, 1'b0);
      drain();

      // Flush with a concurrent request
      fetch(32'h0000_0000, 32'h2408_0001, 1'b0);
      fetch(32'h0000_0004, 32'h2409_0002, 1'b0);
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0000_0040;
      nx_inst       = 32'h2010_0040;
      #1;
      check("flush_req_ready", bus.req_ready, 64'd0);
      step(acc);
      check("flush_no_accept", 64'(acc), 64'd0);
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      check("flush_resp_valid", bus.resp_valid, 64'd0);
      check("flush_resp_inst", bus.resp_inst, NOP);
      fetch(32'h0000_0040, 32'h2010_0040, 1'b0);
      drain();

      // Read-before-write on the same index
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0000_0014;
      nx_inst       = 32'hAAAA_AAAA;
      nx_fault      = 1'b0;
      bus.ld_en     = 1'b1;
      bus.ld_addr   = 32'h0000_0014;
      bus.ld_data   = 32'h5555_5555;
      step(acc);
      check("rbw_accept", 64'(acc), 64'd1);
      bus.req_valid = 1'b0;
      bus.ld_en     = 1'b0;
      fetch(32'h0000_0014, 32'h5555_5555, 1'b0);
      drain();

      // Misaligned and out-of-range pcs
`ifdef INSTMEM_FAULT_CHECK_EN
      fetch(32'h0000_0006, NOP, 1'b1);
      fetch(32'h0008_0000, NOP, 1'b1);
`else
      fetch(32'h0000_0006, 32'h2409_0002, 1'b0);
      fetch(32'h0008_0000, 32'h2408_0001, 1'b0);
`endif
      drain();

      // Reset mid-burst
      fetch(32'h0000_0000, 32'h2408_0001, 1'b0);
      fetch(32'h0000_0004, 32'h2409_0002, 1'b0);
      check("midrst_pre_valid", bus.resp_valid, 64'd1);
      reset = 1'b1;
      step(acc);
      reset = 1'b0;
      check("midrst_resp_valid", bus.resp_valid, 64'd0);
      check("midrst_resp_pc", bus.resp_pc, 64'd0);
      check("midrst_resp_inst", bus.resp_inst, NOP);
      fetch(32'h0000_0000, 32'h2408_0001, 1'b0);
      fetch(32'h0000_000C, 32'h0800_0000, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
